// File: rtl/cut_position_scheduler_pkg.sv
// Shared constants and state encoding for the cut position key-stream controller.
// Contents:
//   LFSR_WIDTH / CUT_BITS / FIELD_BITS : default datapath widths
//   LFSR_TAPS                          : Galois feedback mask used by both link ends
//   sched_state_e                      : controller states (IDLE=0, ACTIVE=1, BLANK=2)
package cut_position_scheduler_pkg;

  localparam int              LFSR_WIDTH = 16;
  localparam int              CUT_BITS   = 8;
  localparam int              FIELD_BITS = 8;
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cut_position_scheduler_lfsr.sv
// galois_lfsr_step: combinational next state of a right-shifting Galois LFSR.
// Ports:
//   cur : current LFSR value
//   nxt : value after one step; the taps are folded in when the bit shifted out is 1
module galois_lfsr_step #(
  parameter int              W    = 16,
  parameter logic [W-1:0]    TAPS = 16'hB400
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = {1'b0, cur[W-1:1]} ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/cut_position_scheduler.sv
// cut_position_scheduler: per-line key-stream controller for line_rotator.
// Emits one keyed cut value per active line from a Galois LFSR that is
// reseeded every field from (key ^ {field_count, field_count}).
// Ports:
//   clk, reset_n     : pixel clock, async active-low reset
//   H, V             : horizontal / vertical blanking flags (1 = blanking)
//   key_in/key_valid : key offer; key_ready high while the pending slot is free
//   raw_cut_position : cut value for the rotator, stable through H blanking
//   cut_valid        : raw_cut_position currently carries a keyed value
//   field_count      : fields seeded since the current key took effect
//   locked           : nonzero key active and at least one field seeded
module cut_position_scheduler
  import cut_position_scheduler_pkg::*;
#(
  parameter int                    LFSR_W  = LFSR_WIDTH,
  parameter int                    CUT_W   = CUT_BITS,
  parameter int                    FIELD_W = FIELD_BITS,
  parameter logic [LFSR_W-1:0]     TAPS    = LFSR_TAPS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               H,
  input  logic               V,
  input  logic [LFSR_W-1:0]  key_in,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [CUT_W-1:0]   raw_cut_position,
  output logic               cut_valid,
  output logic [FIELD_W-1:0] field_count,
  output logic               locked
);

  sched_state_e       state_q, state_d;
  logic               prev_h, prev_v;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_nxt;
  logic [CUT_W-1:0]   cut_q, cut_d;
  logic               valid_q, valid_d;
  logic [FIELD_W-1:0] fc_q, fc_d;
  logic               locked_q, locked_d;
  logic [LFSR_W-1:0]  akey_q, akey_d;
  logic [LFSR_W-1:0]  pkey_q, pkey_d;
  logic               pflag_q, pflag_d;

  logic               h_rise, v_rise, v_fall, hs;
  logic [LFSR_W-1:0]  sel_key, seed_raw, seed;
  logic [FIELD_W-1:0] fc_base;

  assign h_rise = !prev_h && H;
  assign v_rise = !prev_v && V;
  assign v_fall = prev_v && !V;
  assign hs     = key_valid && !pflag_q;

  // A pending key takes effect at the field boundary and restarts the count.
  assign sel_key  = pflag_q ? pkey_q : akey_q;
  assign fc_base  = pflag_q ? '0 : fc_q;
  assign seed_raw = sel_key ^ LFSR_W'({fc_base, fc_base});
  // An all-zero Galois LFSR would lock up, so force a live seed.
  assign seed     = (seed_raw == '0) ? LFSR_W'(1) : seed_raw;

  galois_lfsr_step #(.W(LFSR_W), .TAPS(TAPS)) u_step (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cut_d    = cut_q;
    valid_d  = valid_q;
    fc_d     = fc_q;
    locked_d = locked_q;
    akey_d   = akey_q;
    pkey_d   = pkey_q;
    pflag_d  = pflag_q;

    if (v_fall) begin
      // Field start outranks any coincident H edge: seed only, no step.
      akey_d  = sel_key;
      pflag_d = 1'b0;
      if (sel_key == '0) begin
        state_d  = ST_IDLE;
        lfsr_d   = '0;
        cut_d    = '0;
        valid_d  = 1'b0;
        fc_d     = '0;
        locked_d = 1'b0;
      end else begin
        state_d  = ST_ACTIVE;
        lfsr_d   = seed;
        cut_d    = seed[CUT_W-1:0];
        valid_d  = 1'b1;
        fc_d     = FIELD_W'(fc_base + 1'b1);
        locked_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_ACTIVE: begin
          if (v_rise) begin
            // Identity rotation through vertical blanking.
            state_d = ST_BLANK;
            cut_d   = '0;
            valid_d = 1'b0;
          end else if (h_rise && !V) begin
            cut_d  = lfsr_q[CUT_W-1:0];
            lfsr_d = lfsr_nxt;
          end
        end
        ST_BLANK: begin
          cut_d   = '0;
          valid_d = 1'b0;
        end
        default: begin
          cut_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    // Taken after the V_fall decision so a coincident offer waits a field.
    if (hs) begin
      pkey_d  = key_in;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      prev_h   <= H;
      prev_v   <= V;
      lfsr_q   <= '0;
      cut_q    <= '0;
      valid_q  <= 1'b0;
      fc_q     <= '0;
      locked_q <= 1'b0;
      akey_q   <= '0;
      pkey_q   <= '0;
      pflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_h   <= H;
      prev_v   <= V;
      lfsr_q   <= lfsr_d;
      cut_q    <= cut_d;
      valid_q  <= valid_d;
      fc_q     <= fc_d;
      locked_q <= locked_d;
      akey_q   <= akey_d;
      pkey_q   <= pkey_d;
      pflag_q  <= pflag_d;
    end
  end

  assign key_ready        = !pflag_q;
  assign raw_cut_position = cut_q;
  assign cut_valid        = valid_q;
  assign field_count      = fc_q;
  assign locked           = locked_q;

endmodule
